// File: rtl/memory_pkg.sv
// Shared definitions for the main memory model.
// - Default parameter values for main_memory.
// - FSM state encoding.
// - idx_w(): width of an index over n items; the result is at least 1.
package memory_pkg;

  localparam int DEF_MEMORY_LOCATIONS = 4096;
  localparam int DEF_ADDRESS_SIZE     = 12;
  localparam int DEF_CACHE_LINE_SIZE  = 128;
  localparam int DEF_NUM_PORTS        = 2;
  localparam int DEF_LATENCY          = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } mem_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin selector for the requester ports.
// Ports:
//   req       - request vector, one bit per port
//   ptr       - port that has the highest priority in this cycle
//   grant     - one-hot grant; all zero when nothing is requested
//   grant_idx - index of the granted port
module round_robin_arbiter
  import memory_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  localparam int PW = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        grant_idx
);

  logic          found;
  logic [PW-1:0] p;

  // Walk the ports in order, starting at ptr. The first port that is
  // requesting wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    p         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = PW'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[p]) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = p;
      end
    end
  end

endmodule

// File: rtl/main_memory.sv
// Byte-addressed main memory. Several cache ports share one memory,
// and one whole line is transferred per access.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   req_valid/req_write - per-port request flag and direction
//   req_address         - per-port byte address; port p is in slice p
//   req_data            - per-port write line; port p is in slice p
//   req_ack             - one-cycle pulse when a port's request is accepted
//   data_ready          - one-cycle pulse when that port's request completes
//   data_out            - last line read; byte i is at bits [8i+7:8i]
//   busy                - high while an access is in flight
module main_memory
  import memory_pkg::*;
#(
  parameter int MEMORY_LOCATIONS = DEF_MEMORY_LOCATIONS,
  parameter int ADDRESS_SIZE     = DEF_ADDRESS_SIZE,
  parameter int CACHE_LINE_SIZE  = DEF_CACHE_LINE_SIZE,
  parameter int NUM_PORTS        = DEF_NUM_PORTS,
  parameter int LATENCY          = DEF_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS*ADDRESS_SIZE-1:0]    req_address,
  input  logic [NUM_PORTS*CACHE_LINE_SIZE-1:0] req_data,
  output logic [NUM_PORTS-1:0]                 req_ack,
  output logic [NUM_PORTS-1:0]                 data_ready,
  output logic [CACHE_LINE_SIZE-1:0]           data_out,
  output logic                                 busy
);

  localparam int BYTES = CACHE_LINE_SIZE / 8;
  localparam int PW    = idx_w(NUM_PORTS);
  localparam int CW    = idx_w(LATENCY);
  // Clearing the offset bits aligns every access to a line boundary, so
  // a line access cannot wrap past the top of memory.
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(BYTES - 1);

  mem_state_e                  state, state_nxt;
  logic [CW-1:0]               cnt;
  logic [7:0]                  mem [MEMORY_LOCATIONS];
  logic [PW-1:0]               rr_ptr, gnt_idx, arb_idx;
  logic [NUM_PORTS-1:0]        arb_grant;
  logic                        lat_write;
  logic [ADDRESS_SIZE-1:0]     lat_base;
  logic [CACHE_LINE_SIZE-1:0]  lat_line;
  logic                        accept, enter_respond, rd_write;
  logic [ADDRESS_SIZE-1:0]     rd_base;
  logic [CACHE_LINE_SIZE-1:0]  rd_line;

  round_robin_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign accept = (state == IDLE) && (|req_valid) && !rst;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ack       = '0;
    data_ready    = '0;
    enter_respond = 1'b0;
    unique case (state)
      IDLE: if (|req_valid) begin
        req_ack = arb_grant;
        if (LATENCY == 1) begin
          state_nxt     = RESPOND;
          enter_respond = 1'b1;
        end else begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: if (cnt == '0) begin
        state_nxt     = RESPOND;
        enter_respond = 1'b1;
      end
      RESPOND: begin
        data_ready[gnt_idx] = 1'b1;
        state_nxt           = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset wins over everything: the outputs stay quiet while it is high.
    if (rst) begin
      req_ack    = '0;
      data_ready = '0;
    end
  end

  // The line is loaded into data_out on the edge that enters RESPOND, so
  // the data is already valid in the cycle where data_ready is high. When
  // LATENCY=1 that edge is the acceptance edge itself. Nothing is latched
  // yet at that point, so the address comes from the live request.
  always_comb begin
    rd_base  = lat_base;
    rd_write = lat_write;
    rd_line  = '0;
    if (state == IDLE) begin
      rd_base  = req_address[arb_idx*ADDRESS_SIZE +: ADDRESS_SIZE] & ALIGN_MASK;
      rd_write = req_write[arb_idx];
    end
    for (int i = 0; i < BYTES; i++)
      rd_line[8*i +: 8] = mem[rd_base + ADDRESS_SIZE'(i)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      lat_write <= 1'b0;
      lat_base  <= '0;
      lat_line  <= '0;
      data_out  <= '0;
    end else begin
      if (accept) begin
        gnt_idx   <= arb_idx;
        rr_ptr    <= (int'(arb_idx) == NUM_PORTS - 1) ? '0 : arb_idx + 1'b1;
        lat_write <= req_write[arb_idx];
        lat_base  <= rd_base;
        lat_line  <= req_data[arb_idx*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
        cnt       <= CW'((LATENCY > 1) ? LATENCY - 2 : 0);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_respond && !rd_write) data_out <= rd_line;
    end
  end

  // The storage has no reset. A reset that lands in RESPOND suppresses
  // the write.
  always_ff @(posedge clk) begin
    if (!rst && state == RESPOND && lat_write)
      for (int i = 0; i < BYTES; i++)
        mem[lat_base + ADDRESS_SIZE'(i)] <= lat_line[8*i +: 8];
  end

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory. It builds two instances: LATENCY=5 (index 0) and
// LATENCY=1 (index 1). A transaction-level model checks every cycle, and
// directed sequences add hand-computed literal checks.
module tb_main_memory;
  localparam int NP = 2, AW = 12, LW = 128, ML = 4096, NB = LW / 8;

  localparam logic [LW-1:0] LA = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [LW-1:0] LB = 128'hA5A5A5A5_01020304_05060708_5A5A5A5A;
  localparam logic [LW-1:0] LC = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [LW-1:0] LD = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [LW-1:0] LE = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  logic clk = 1'b0;
  logic rst_i [2];
  logic [NP-1:0]    r_valid [2], r_write [2], ack [2], dr [2];
  logic [NP*AW-1:0] r_addr [2];
  logic [NP*LW-1:0] r_data [2];
  logic [LW-1:0]    dout [2];
  logic             busy_o [2];
  int cyc = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_memory #(.LATENCY(5)) u_dut5 (
    .clk(clk), .rst(rst_i[0]), .req_valid(r_valid[0]), .req_write(r_write[0]),
    .req_address(r_addr[0]), .req_data(r_data[0]), .req_ack(ack[0]),
    .data_ready(dr[0]), .data_out(dout[0]), .busy(busy_o[0]));

  main_memory #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_i[1]), .req_valid(r_valid[1]), .req_write(r_write[1]),
    .req_address(r_addr[1]), .req_data(r_data[1]), .req_ack(ack[1]),
    .data_ready(dr[1]), .data_out(dout[1]), .busy(busy_o[1]));

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model state. A request is accepted in cycle t when nothing is
  // outstanding. It completes in cycle t+L, and the read data is visible
  // in that same cycle.
  logic [7:0]    mm [2][ML];
  bit            out_f [2];
  int            acc_c [2], gp [2], ptr [2];
  bit            g_wr [2];
  int            g_base [2];
  logic [LW-1:0] g_line [2], exp_do [2];

  function automatic logic [LW-1:0] mline(input int k, input int base);
    logic [LW-1:0] l;
    for (int i = 0; i < NB; i++) l[8*i +: 8] = mm[k][base + i];
    return l;
  endfunction

  task automatic step(input int k);
    int L, g;
    logic [NP-1:0] e_ack, e_dr;
    logic e_busy;
    L = (k == 0) ? 5 : 1;
    e_ack = '0; e_dr = '0; g = -1;
    e_busy = out_f[k] && (cyc > acc_c[k]);
    if (out_f[k] && cyc == acc_c[k] + L) begin
      if (!rst_i[k]) e_dr[gp[k]] = 1'b1;
      if (!g_wr[k]) exp_do[k] = mline(k, g_base[k]);
    end
    if (!rst_i[k] && !out_f[k])
      for (int i = 0; i < NP; i++)
        if (g < 0 && r_valid[k][(ptr[k] + i) % NP]) g = (ptr[k] + i) % NP;
    if (g >= 0) e_ack[g] = 1'b1;
    chk($sformatf("ack%0d", k), LW'(ack[k]), LW'(e_ack));
    chk($sformatf("data_ready%0d", k), LW'(dr[k]), LW'(e_dr));
    chk($sformatf("busy%0d", k), LW'(busy_o[k]), LW'(e_busy));
    chk($sformatf("data_out%0d", k), dout[k], exp_do[k]);
    if (rst_i[k]) begin
      out_f[k] = 0; ptr[k] = 0; exp_do[k] = '0;
    end else begin
      if (e_dr != '0) begin
        if (g_wr[k]) for (int i = 0; i < NB; i++) mm[k][g_base[k] + i] = g_line[k][8*i +: 8];
        out_f[k] = 0;
      end
      if (g >= 0) begin
        out_f[k]  = 1; acc_c[k] = cyc; gp[k] = g;
        g_wr[k]   = r_write[k][g];
        g_base[k] = int'(r_addr[k][g*AW +: AW]) & ~(NB - 1);
        g_line[k] = r_data[k][g*LW +: LW];
        ptr[k]    = (g + 1) % NP;
      end
    end
  endtask

  always @(negedge clk) begin
    step(0);
    step(1);
  end

  // Single request on instance k, port p. With scr set, the fields are
  // corrupted after the ack to show they were latched at acceptance.
  task automatic do_req(input int k, input int p, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input bit scr,
                        output int t_ack, output int t_dr, output logic [LW-1:0] q);
    @(posedge clk); #1;
    r_valid[k][p] = 1'b1; r_write[k][p] = wr;
    r_addr[k][p*AW +: AW] = a; r_data[k][p*LW +: LW] = d;
    t_ack = -1; t_dr = -1; q = '0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ack[k][p]) t_ack = cyc;
      if (dr[k][p]) begin t_dr = cyc; q = dout[k]; break; end
      @(posedge clk); #1;
      if (scr && t_ack >= 0) begin
        r_addr[k][p*AW +: AW] = ~a; r_data[k][p*LW +: LW] = ~d; r_write[k][p] = ~wr;
      end
    end
    @(posedge clk); #1;
    r_valid[k][p] = 1'b0;
    chk("req_completes", LW'(t_dr >= 0 && t_ack >= 0), LW'(1));
  endtask

  initial begin
    int ta, td, nd, qa [2], qd [2];
    logic [LW-1:0] q, dd [2];
    int acks_c [$], acks_p [$];
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b1; r_valid[k] = '0; r_write[k] = '0; r_addr[k] = '0; r_data[k] = '0;
      out_f[k] = 0; ptr[k] = 0; exp_do[k] = '0; acc_c[k] = 0; gp[k] = 0;
    end
    repeat (3) @(posedge clk); #1;
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    @(negedge clk);
    chk("reset_busy", LW'(busy_o[0]), LW'(0));
    chk("reset_dout", dout[0], '0);

    // Write then read the same line; a misaligned read returns the same line.
    do_req(0, 0, 1'b1, 12'h010, LA, 1'b1, ta, td, q);
    chk("wr_latency", LW'(td - ta), LW'(5));
    do_req(0, 0, 1'b0, 12'h010, '0, 1'b1, ta, td, q);
    chk("rd_latency", LW'(td - ta), LW'(5));
    chk("rd_010", q, LA);
    do_req(0, 1, 1'b0, 12'h01F, '0, 1'b0, ta, td, q);
    chk("rd_01F_aligned", q, LA);

    // A reset 3 cycles after a write ack must abort the write.
    do_req(0, 1, 1'b1, 12'h020, LB, 1'b0, ta, td, q);
    @(posedge clk); #1;
    r_valid[0][0] = 1'b1; r_write[0][0] = 1'b1; r_addr[0][AW-1:0] = 12'h020; r_data[0][LW-1:0] = LC;
    ta = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ack[0][0]) begin ta = cyc; break; end
      @(posedge clk); #1;
    end
    chk("abort_ack_seen", LW'(ta >= 0), LW'(1));
    repeat (3) @(posedge clk); #1;
    rst_i[0] = 1'b1; r_valid[0][0] = 1'b0;
    @(posedge clk); #1;
    rst_i[0] = 1'b0;
    nd = 0;
    repeat (8) begin @(negedge clk); if (dr[0] != '0) nd++; end
    chk("abort_no_ready", LW'(nd), LW'(0));
    chk("abort_dout_cleared", dout[0], '0);
    do_req(0, 0, 1'b0, 12'h020, '0, 1'b0, ta, td, q);
    chk("abort_keeps_old", q, LB);

    // Last line in memory; line 0 must be untouched.
    do_req(0, 0, 1'b1, 12'h000, LD, 1'b0, ta, td, q);
    do_req(0, 1, 1'b1, 12'hFF0, LE, 1'b0, ta, td, q);
    do_req(0, 0, 1'b0, 12'hFF0, '0, 1'b0, ta, td, q);
    chk("rd_FF0", q, LE);
    do_req(0, 1, 1'b0, 12'hFFF, '0, 1'b0, ta, td, q);
    chk("rd_FFF_aligned", q, LE);
    do_req(0, 0, 1'b0, 12'h000, '0, 1'b0, ta, td, q);
    chk("rd_000_unchanged", q, LD);

    // Both ports valid from the reset cycle and held: grants alternate.
    @(posedge clk); #1;
    rst_i[0] = 1'b1; r_valid[0] = 2'b11; r_write[0] = 2'b00; r_addr[0] = {12'h020, 12'h010};
    @(posedge clk); #1;
    rst_i[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ack[0] != '0) begin acks_c.push_back(cyc); acks_p.push_back(ack[0][1] ? 1 : 0); end
    end
    @(posedge clk); #1;
    r_valid[0] = '0;
    repeat (8) @(negedge clk);
    chk("arb_ack_count", LW'(acks_c.size()), LW'(4));
    if (acks_c.size() >= 3) begin
      chk("arb_first_p0", LW'(acks_p[0]), LW'(0));
      chk("arb_second_p1", LW'(acks_p[1]), LW'(1));
      chk("arb_third_p0", LW'(acks_p[2]), LW'(0));
      chk("arb_gap1", LW'(acks_c[1] - acks_c[0]), LW'(6));
      chk("arb_gap2", LW'(acks_c[2] - acks_c[1]), LW'(6));
    end

    // LATENCY=1 instance.
    do_req(1, 0, 1'b1, 12'h000, LD, 1'b1, ta, td, q);
    chk("l1_wr_latency", LW'(td - ta), LW'(1));
    do_req(1, 1, 1'b1, 12'hFF0, LE, 1'b0, ta, td, q);
    @(posedge clk); #1;
    r_valid[1] = 2'b11; r_write[1] = 2'b00; r_addr[1] = {12'hFF0, 12'h000};
    qa[0] = -1; qa[1] = -1; qd[0] = -1; qd[1] = -1; dd[0] = '0; dd[1] = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (ack[1][p]) qa[p] = cyc;
        if (dr[1][p]) begin qd[p] = cyc; dd[p] = dout[1]; end
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (qd[p] >= 0) r_valid[1][p] = 1'b0;
      if (qd[0] >= 0 && qd[1] >= 0) break;
    end
    chk("l1_ack_gap", LW'(qa[1] - qa[0]), LW'(2));
    chk("l1_ready0", LW'(qd[0] - qa[0]), LW'(1));
    chk("l1_ready1", LW'(qd[1] - qa[1]), LW'(1));
    chk("l1_rd_000", dd[0], LD);
    chk("l1_rd_FF0", dd[1], LE);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
